// File: rtl/fpga_status_led_pkg.sv
// fpga_status_led_pkg: shared mode/state encodings and counter sizing for the status LED controller
package fpga_status_led_pkg;
  typedef enum logic [1:0] {LED_OFF, LED_ON, LED_HEARTBEAT, LED_ACTIVITY} led_mode_e;
  typedef enum logic [2:0] {CS_IDLE, CS_SOLID, CS_ON, CS_OFF, CS_PAUSE} code_state_e;
  function automatic int cnt_w(input int max);
    return (max < 1) ? 1 : $clog2(max + 1);
  endfunction
endpackage

// File: rtl/fpga_status_led_ctrl_if.sv
// fpga_status_led_ctrl_if: mode/event/exit inputs and LED outputs of the status LED controller
interface fpga_status_led_ctrl_if #(
  parameter int NUM_LEDS = 4,
  parameter int CODE_W   = 4
);
  logic [2*NUM_LEDS-1:0] mode_i;
  logic [NUM_LEDS-1:0]   event_i;
  logic                  exit_valid_i;
  logic [CODE_W-1:0]     exit_value_i;
  logic [NUM_LEDS-1:0]   led_o;
  logic                  code_led_o;
  logic                  code_active_o;
  logic                  tick_o;
  modport master (
    output mode_i, event_i, exit_valid_i, exit_value_i,
    input  led_o, code_led_o, code_active_o, tick_o
  );
  modport slave (
    input  mode_i, event_i, exit_valid_i, exit_value_i,
    output led_o, code_led_o, code_active_o, tick_o
  );
endinterface

// File: rtl/fpga_status_led_stretch.sv
// fpga_status_led_stretch: one activity pulse-stretch counter, cleared while its channel is not in activity mode
module fpga_status_led_stretch
  import fpga_status_led_pkg::*;
#(
  parameter int STRETCH_TICKS = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic ev,
  input  logic tick,
  output logic active
);
  localparam int W = cnt_w(STRETCH_TICKS);
  logic [W-1:0] cnt, cnt_nxt;
  // reload beats a coincident tick; active looks at the next value so the LED lights one cycle after the event
  always_comb cnt_nxt = !en ? '0 : ev ? W'(STRETCH_TICKS) : (tick && cnt != '0) ? cnt - 1'b1 : cnt;
  assign active = cnt_nxt != '0;
  // counter register
  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else cnt <= cnt_nxt;
  end
endmodule

// File: rtl/fpga_status_led_ctrl.sv
// fpga_status_led_ctrl: mode-controlled status LEDs plus an exit-code LED that blinks the code repeatedly
module fpga_status_led_ctrl
  import fpga_status_led_pkg::*;
#(
  parameter int NUM_LEDS      = 4,
  parameter int TICK_DIV      = 20000,
  parameter int HB_TICKS      = 250,
  parameter int STRETCH_TICKS = 50,
  parameter int BLINK_TICKS   = 200,
  parameter int PAUSE_TICKS   = 1000,
  parameter int CODE_W        = 4
) (
  input logic                   clk_i,
  input logic                   rst_i,
  fpga_status_led_ctrl_if.slave bus
);
  localparam int DIV_W = cnt_w(TICK_DIV);
  localparam int HB_W  = cnt_w(HB_TICKS);
  localparam int PH_W  = cnt_w(BLINK_TICKS > PAUSE_TICKS ? BLINK_TICKS : PAUSE_TICKS);
  localparam logic [2:0] S_IDLE  = CS_IDLE;
  localparam logic [2:0] S_SOLID = CS_SOLID;
  localparam logic [2:0] S_ON    = CS_ON;
  localparam logic [2:0] S_OFF   = CS_OFF;
  localparam logic [2:0] S_PAUSE = CS_PAUSE;
  if (NUM_LEDS < 1 || TICK_DIV < 2 || HB_TICKS < 1 || STRETCH_TICKS < 1 ||
      BLINK_TICKS < 1 || PAUSE_TICKS < 1 || CODE_W < 1) begin : g_bad_params
    $error("fpga_status_led_ctrl: illegal parameter value");
  end
  logic [DIV_W-1:0]    div_cnt;
  logic                tick;
  logic [HB_W-1:0]     hb_cnt;
  logic                hb_q;
  logic [NUM_LEDS-1:0] act, led_nxt;
  logic [2:0]          state, state_nxt;
  logic [PH_W-1:0]     phase, phase_nxt, dur;
  logic [CODE_W-1:0]   code_q, code_nxt, bc, bc_nxt;
  logic                ev_q, rise, done;
  assign bus.tick_o = tick;
  // time base: tick is a registered strobe following the last divider count
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_cnt <= '0;
      tick    <= 1'b0;
    end else begin
      div_cnt <= (div_cnt == DIV_W'(TICK_DIV - 1)) ? '0 : div_cnt + 1'b1;
      tick    <= div_cnt == DIV_W'(TICK_DIV - 1);
    end
  end
  // shared heartbeat: toggles every HB_TICKS ticks so all heartbeat channels stay in phase
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hb_cnt <= '0;
      hb_q   <= 1'b0;
    end else if (tick) begin
      hb_cnt <= (hb_cnt == HB_W'(HB_TICKS - 1)) ? '0 : hb_cnt + 1'b1;
      hb_q   <= hb_q ^ (hb_cnt == HB_W'(HB_TICKS - 1));
    end
  end
  for (genvar k = 0; k < NUM_LEDS; k++) begin : g_ch
    logic [1:0] m;
    assign m = bus.mode_i[2*k +: 2];
    fpga_status_led_stretch #(.STRETCH_TICKS(STRETCH_TICKS)) u_stretch (
      .clk    (clk_i),
      .rst    (rst_i),
      .en     (m == LED_ACTIVITY),
      .ev     (bus.event_i[k]),
      .tick   (tick),
      .active (act[k])
    );
    assign led_nxt[k] = (m == LED_ON) | ((m == LED_HEARTBEAT) & hb_q) | act[k];
  end
  // channel LED drive register
  always_ff @(posedge clk_i) begin
    if (rst_i) bus.led_o <= '0;
    else bus.led_o <= led_nxt;
  end
  assign rise = bus.exit_valid_i & ~ev_q;
  assign dur  = (state == S_PAUSE) ? PH_W'(PAUSE_TICKS) : PH_W'(BLINK_TICKS);
  assign done = tick && (phase + 1'b1 == dur);
  // exit-code sequencer: first exit edge wins, then ON/OFF pairs per code unit and a dark pause
  always_comb begin
    state_nxt = state;
    phase_nxt = phase;
    bc_nxt    = bc;
    code_nxt  = code_q;
    if (state == S_IDLE) begin
      if (rise) begin
        code_nxt  = bus.exit_value_i;
        bc_nxt    = '0;
        phase_nxt = '0;
        state_nxt = (bus.exit_value_i == '0) ? S_SOLID : S_ON;
      end
    end else if (state != S_SOLID && tick) begin
      phase_nxt = done ? '0 : phase + 1'b1;
      if (done) begin
        state_nxt = (state == S_ON) ? S_OFF : (state == S_OFF && bc >= code_q) ? S_PAUSE : S_ON;
        bc_nxt    = (state == S_ON) ? bc + 1'b1 : (state == S_OFF && bc >= code_q) ? '0 : bc;
      end
    end
  end
  // sequencer state plus code LED/active flags registered from the next state
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state             <= S_IDLE;
      phase             <= '0;
      bc                <= '0;
      code_q            <= '0;
      ev_q              <= 1'b0;
      bus.code_led_o    <= 1'b0;
      bus.code_active_o <= 1'b0;
    end else begin
      state             <= state_nxt;
      phase             <= phase_nxt;
      bc                <= bc_nxt;
      code_q            <= code_nxt;
      ev_q              <= bus.exit_valid_i;
      bus.code_led_o    <= (state_nxt == S_SOLID) || (state_nxt == S_ON);
      bus.code_active_o <= state_nxt != S_IDLE;
    end
  end
endmodule

// File: tb/tb_fpga_status_led_ctrl.sv
// tb_fpga_status_led_ctrl: randomized bench checked against a tick-arithmetic reference model
module tb_fpga_status_led_ctrl;
  localparam int NL = 4, CW = 4, TD = 4, HB = 2, ST = 3, BL = 2, PA = 4;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int tests = 0;
  int fails = 0;
  fpga_status_led_ctrl_if #(.NUM_LEDS(NL), .CODE_W(CW)) bus();
  fpga_status_led_ctrl #(
    .NUM_LEDS(NL), .TICK_DIV(TD), .HB_TICKS(HB), .STRETCH_TICKS(ST),
    .BLINK_TICKS(BL), .PAUSE_TICKS(PA), .CODE_W(CW)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  // model state: n = clock edges since reset release
  int         n;
  int         last_ev [NL];
  logic [1:0] mode_s  [NL];
  logic       prev_v;
  bit         latched;
  int         lat_n;
  int         code;
  // ticks seen by the design at edges 1..m
  function automatic int ticks(input int m);
    return (m >= 1) ? (m - 1) / TD : 0;
  endfunction
  function automatic logic exp_tick();
    return n > 0 && n % TD == 0;
  endfunction
  function automatic logic [NL-1:0] exp_led();
    logic [NL-1:0] v;
    v = '0;
    for (int k = 0; k < NL; k++)
      case (mode_s[k])
        2'd1:    v[k] = 1'b1;
        2'd2:    v[k] = (ticks(n - 1) / HB) % 2 == 1;
        2'd3:    v[k] = last_ev[k] >= 0 && ticks(n) - ticks(last_ev[k]) < ST;
        default: v[k] = 1'b0;
      endcase
    return v;
  endfunction
  function automatic logic exp_code_led();
    int p;
    if (!latched) return 1'b0;
    if (code == 0) return 1'b1;
    p = (ticks(n) - ticks(lat_n)) % (code * 2 * BL + PA);
    return p < code * 2 * BL && (p % (2 * BL)) < BL;
  endfunction
  task automatic step();
    @(posedge clk);
    if (rst) begin
      n = 0; prev_v = 1'b0; latched = 1'b0; lat_n = 0; code = 0;
      for (int k = 0; k < NL; k++) begin last_ev[k] = -1; mode_s[k] = 2'd0; end
    end else begin
      n++;
      for (int k = 0; k < NL; k++) begin
        mode_s[k] = bus.mode_i[2*k +: 2];
        if (mode_s[k] != 2'd3) last_ev[k] = -1;
        else if (bus.event_i[k]) last_ev[k] = n;
      end
      if (bus.exit_valid_i && !prev_v && !latched) begin
        latched = 1'b1; lat_n = n; code = int'(bus.exit_value_i);
      end
      prev_v = bus.exit_valid_i;
    end
    #1;
  endtask
  task automatic apply_reset();
    bus.exit_valid_i = 1'b0;
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    bus.mode_i = 8'($urandom); bus.event_i = 4'($urandom); bus.exit_valid_i = 1'b1; bus.exit_value_i = 4'd3;
    rst = 1'b1;
    step();
    step();
    tests++; if (bus.led_o !== 4'b0) begin fails++; $display("FAIL reset led_o got %b exp 0000", bus.led_o); end
    tests++; if (bus.code_led_o !== 1'b0) begin fails++; $display("FAIL reset code_led_o got %b exp 0", bus.code_led_o); end
    tests++; if (bus.code_active_o !== 1'b0) begin fails++; $display("FAIL reset code_active_o got %b exp 0", bus.code_active_o); end
    tests++; if (bus.tick_o !== 1'b0) begin fails++; $display("FAIL reset tick_o got %b exp 0", bus.tick_o); end
    bus.mode_i = '0; bus.event_i = '0; bus.exit_valid_i = 1'b0;
    rst = 1'b0;
  endtask
  task automatic test_time_base();
    bus.mode_i = 8'b10_10_01_00;
    for (int i = 0; i < 40; i++) begin
      step();
      tests++; if (bus.tick_o !== exp_tick()) begin fails++; $display("FAIL time_base tick n=%0d got %b exp %b", n, bus.tick_o, exp_tick()); end
      tests++; if (bus.led_o !== exp_led()) begin fails++; $display("FAIL time_base led n=%0d got %b exp %b", n, bus.led_o, exp_led()); end
    end
  endtask
  task automatic test_activity();
    bus.mode_i = 8'b00_00_00_11;
    for (int r = 0; r < 3; r++) begin
      if (r == 2)
        for (int i = 0; i < 2 * TD && bus.tick_o !== 1'b1; i++) step();
      bus.event_i = 4'b0001;
      step();
      bus.event_i = 4'b0000;
      tests++; if (bus.led_o[0] !== 1'b1) begin fails++; $display("FAIL activity rise r=%0d got %b exp 1", r, bus.led_o[0]); end
      for (int i = 0; i < (r == 1 ? 6 : 18); i++) begin
        step();
        tests++; if (bus.led_o !== exp_led()) begin fails++; $display("FAIL activity led r=%0d n=%0d got %b exp %b", r, n, bus.led_o, exp_led()); end
      end
    end
    for (int i = 0; i < 150; i++) begin
      bus.event_i = {3'b0, $urandom_range(7) == 0};
      step();
      tests++; if (bus.led_o !== exp_led()) begin fails++; $display("FAIL activity rand n=%0d got %b exp %b", n, bus.led_o, exp_led()); end
    end
    bus.event_i = '0;
  endtask
  task automatic test_modes_random();
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(9) == 0) bus.mode_i = 8'($urandom);
      bus.event_i = 4'($urandom & $urandom);
      step();
      tests++; if (bus.led_o !== exp_led()) begin fails++; $display("FAIL modes_random n=%0d got %b exp %b", n, bus.led_o, exp_led()); end
      tests++; if (bus.tick_o !== exp_tick()) begin fails++; $display("FAIL modes_random tick n=%0d got %b exp %b", n, bus.tick_o, exp_tick()); end
    end
    bus.event_i = '0;
  endtask
  task automatic test_mode_clear();
    bus.mode_i = 8'b00_11_00_00;
    bus.event_i = 4'b0100;
    step();
    bus.event_i = 4'b0000;
    for (int i = 0; i < 2 * TD && ticks(n) - ticks(last_ev[2]) < 1; i++) step();
    tests++; if (bus.led_o[2] !== 1'b1) begin fails++; $display("FAIL mode_clear lit before switch got %b exp 1", bus.led_o[2]); end
    bus.mode_i = 8'b00_00_00_00;
    for (int i = 0; i < 3; i++) step();
    bus.mode_i = 8'b00_11_00_00;
    for (int i = 0; i < 16; i++) begin
      step();
      tests++; if (bus.led_o[2] !== 1'b0) begin fails++; $display("FAIL mode_clear n=%0d got %b exp 0", n, bus.led_o[2]); end
    end
    bus.mode_i = '0;
  endtask
  task automatic test_exit_code();
    apply_reset();
    bus.exit_value_i = 4'd3;
    bus.exit_valid_i = 1'b1;
    for (int i = 0; i < 140; i++) begin
      step();
      tests++; if (bus.code_active_o !== 1'b1) begin fails++; $display("FAIL exit_code active n=%0d got %b exp 1", n, bus.code_active_o); end
      tests++; if (bus.code_led_o !== exp_code_led()) begin fails++; $display("FAIL exit_code led n=%0d got %b exp %b", n, bus.code_led_o, exp_code_led()); end
    end
  endtask
  task automatic test_first_wins();
    apply_reset();
    bus.exit_value_i = 4'd0;
    bus.exit_valid_i = 1'b1;
    for (int i = 0; i < 50; i++) begin
      if (i == 10) bus.exit_valid_i = 1'b0;
      if (i == 14) begin bus.exit_value_i = 4'd5; bus.exit_valid_i = 1'b1; end
      step();
      tests++; if (bus.code_led_o !== 1'b1) begin fails++; $display("FAIL first_wins solid n=%0d got %b exp 1", n, bus.code_led_o); end
      tests++; if (bus.code_active_o !== 1'b1) begin fails++; $display("FAIL first_wins active n=%0d got %b exp 1", n, bus.code_active_o); end
    end
  endtask
  task automatic test_reset_mid();
    apply_reset();
    bus.exit_value_i = 4'd3;
    bus.exit_valid_i = 1'b1;
    for (int i = 0; i < 20; i++) step();
    for (int i = 0; i < 40 && bus.code_led_o !== 1'b1; i++) step();
    tests++; if (bus.code_led_o !== 1'b1) begin fails++; $display("FAIL reset_mid no ON phase got %b exp 1", bus.code_led_o); end
    bus.mode_i = 8'b00_00_01_01;
    rst = 1'b1;
    step();
    rst = 1'b0;
    tests++; if ({bus.led_o, bus.code_led_o, bus.code_active_o, bus.tick_o} !== 7'b0) begin fails++; $display("FAIL reset_mid outputs got %b exp 0000000", {bus.led_o, bus.code_led_o, bus.code_active_o, bus.tick_o}); end
    bus.mode_i = '0;
    bus.exit_valid_i = 1'b0;
    step();
    bus.exit_value_i = 4'd2;
    bus.exit_valid_i = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step();
      tests++; if (bus.code_led_o !== exp_code_led()) begin fails++; $display("FAIL reset_mid led n=%0d got %b exp %b", n, bus.code_led_o, exp_code_led()); end
    end
  endtask
  task automatic test_exit_random();
    for (int r = 0; r < 4; r++) begin
      apply_reset();
      bus.exit_value_i = 4'($urandom);
      for (int i = 0; i < int'($urandom_range(7)); i++) step();
      bus.exit_valid_i = 1'b1;
      for (int i = 0; i < 160; i++) begin
        if ($urandom_range(15) == 0) begin bus.exit_valid_i = ~bus.exit_valid_i; bus.exit_value_i = 4'($urandom); end
        step();
        tests++; if (bus.code_led_o !== exp_code_led()) begin fails++; $display("FAIL exit_random led r=%0d n=%0d got %b exp %b", r, n, bus.code_led_o, exp_code_led()); end
        tests++; if (bus.code_active_o !== latched) begin fails++; $display("FAIL exit_random active r=%0d n=%0d got %b exp %b", r, n, bus.code_active_o, latched); end
      end
    end
  endtask
  initial begin
    bus.mode_i = '0; bus.event_i = '0; bus.exit_valid_i = 1'b0; bus.exit_value_i = '0;
    test_reset();
    test_time_base();
    test_activity();
    test_modes_random();
    test_mode_clear();
    test_exit_code();
    test_first_wins();
    test_reset_mid();
    test_exit_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
